// File: rtl/swervolf_irq_pkg.sv
// Shared definitions for the SweRVolf IRQ3/IRQ4 interrupt arbiter.
// Register word offsets, line FSM states and claim word layout.
package swervolf_irq_pkg;

  localparam int N_SRC_MAX = 8;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_ROUTE   = 3'd2;
  localparam logic [2:0] REG_EDGE    = 3'd3;
  localparam logic [2:0] REG_CLAIM3  = 3'd4;
  localparam logic [2:0] REG_CLAIM4  = 3'd5;

  localparam int CLAIM_VALID = 31;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    INSERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/swervolf_irq_line.sv
// One interrupt line: fixed-priority winner select plus
// the claim/complete handshake that owns active_id.
module swervolf_irq_line
  import swervolf_irq_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_eligible,
  input  logic             i_claim,
  input  logic             i_complete,
  input  logic [2:0]       i_complete_id,
  output logic             o_irq,
  output logic [31:0]      o_claim_rdt,
  output logic [N_SRC-1:0] o_claimed
);

  irq_state_e r_state;
  irq_state_e w_next;
  logic [2:0] r_active_id;
  logic [2:0] w_winner;
  logic       w_any;
  logic       w_take;
  logic       w_done;

  always_comb begin
    w_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_eligible[i]) w_winner = 3'(i);
    end
  end

  assign w_any  = |i_eligible;
  assign w_take = i_claim && (r_state == ASSERT) && w_any;
  assign w_done = i_complete && (r_state == INSERVICE) &&
                  (i_complete_id == r_active_id);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_any) w_next = ASSERT;
      ASSERT: begin
        if (w_take)      w_next = INSERVICE;
        else if (!w_any) w_next = IDLE;
      end
      INSERVICE: if (w_done) w_next = w_any ? ASSERT : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_active_id <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) r_active_id <= w_winner;
    end
  end

  // r_state is a flop, so the request output is registered
  assign o_irq = (r_state == ASSERT);

  always_comb begin
    o_claim_rdt = '0;
    if (w_take) begin
      o_claim_rdt[CLAIM_VALID] = 1'b1;
      o_claim_rdt[2:0]         = w_winner;
    end
  end

  always_comb begin
    o_claimed = '0;
    for (int i = 0; i < N_SRC; i++) begin
      o_claimed[i] = w_take && (w_winner == 3'(i));
    end
  end

endmodule

// File: rtl/swervolf_irq_arbiter.sv
// Shares SweRV IRQ3/IRQ4 between up to eight peripheral sources.
// Holds source capture, the register file and Wishbone decode.
module swervolf_irq_arbiter
  import swervolf_irq_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_irq_src,
  input  logic [4:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  output logic             o_irq3,
  output logic             o_irq4
);

  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_src_q_d;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] r_route;
  logic [N_SRC-1:0] r_edge;

  logic             w_req;
  logic             w_we;
  logic             w_re;
  logic [2:0]       w_reg;
  logic [N_SRC-1:0] w_wdat;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_elig3;
  logic [N_SRC-1:0] w_elig4;
  logic [N_SRC-1:0] w_claimed3;
  logic [N_SRC-1:0] w_claimed4;
  logic [31:0]      w_claim3_rdt;
  logic [31:0]      w_claim4_rdt;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // side effects only on the first cycle of each access
  assign w_req  = i_wb_cyc && i_wb_stb && !o_wb_ack;
  assign w_we   = w_req && i_wb_we && i_wb_sel[0];
  assign w_re   = w_req && !i_wb_we;
  assign w_reg  = i_wb_adr[4:2];
  assign w_wdat = i_wb_dat[N_SRC-1:0];

  assign w_unused = ^{i_wb_adr[1:0], i_wb_dat, i_wb_sel[3:1]};

  assign w_w1c  = (w_we && w_reg == REG_PENDING) ? w_wdat : '0;
  assign w_rise = r_src_q & ~r_src_q_d;

  // edge: set wins over W1C/claim clear; level: follows src_q
  assign w_pend_nxt =
    (r_edge & (w_rise |
      (r_pending & ~(w_w1c | w_claimed3 | w_claimed4)))) |
    (~r_edge & r_src_q);

  assign w_elig3 = r_pending & r_enable & ~r_route;
  assign w_elig4 = r_pending & r_enable & r_route;

  swervolf_irq_line #(.N_SRC(N_SRC)) u_line3 (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_eligible    (w_elig3),
    .i_claim       (w_re && w_reg == REG_CLAIM3),
    .i_complete    (w_we && w_reg == REG_CLAIM3),
    .i_complete_id (i_wb_dat[2:0]),
    .o_irq         (o_irq3),
    .o_claim_rdt   (w_claim3_rdt),
    .o_claimed     (w_claimed3)
  );

  swervolf_irq_line #(.N_SRC(N_SRC)) u_line4 (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_eligible    (w_elig4),
    .i_claim       (w_re && w_reg == REG_CLAIM4),
    .i_complete    (w_we && w_reg == REG_CLAIM4),
    .i_complete_id (i_wb_dat[2:0]),
    .o_irq         (o_irq4),
    .o_claim_rdt   (w_claim4_rdt),
    .o_claimed     (w_claimed4)
  );

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_PENDING: w_rdata = 32'(r_pending);
      REG_ENABLE:  w_rdata = 32'(r_enable);
      REG_ROUTE:   w_rdata = 32'(r_route);
      REG_EDGE:    w_rdata = 32'(r_edge);
      REG_CLAIM3:  w_rdata = w_claim3_rdt;
      REG_CLAIM4:  w_rdata = w_claim4_rdt;
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src_q   <= '0;
      r_src_q_d <= '0;
      r_pending <= '0;
      r_enable  <= '0;
      r_route   <= '0;
      r_edge    <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_rdt  <= '0;
    end else begin
      r_src_q   <= i_irq_src;
      r_src_q_d <= r_src_q;
      r_pending <= w_pend_nxt;
      o_wb_ack  <= w_req;
      o_wb_rdt  <= w_re ? w_rdata : '0;
      if (w_we) begin
        case (w_reg)
          REG_ENABLE: r_enable <= w_wdat;
          REG_ROUTE:  r_route  <= w_wdat;
          REG_EDGE:   r_edge   <= w_wdat;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swervolf_irq_arbiter.sv
// Directed self-checking bench for swervolf_irq_arbiter.
// Each task drives one scenario and checks hand-derived values.
module tb_swervolf_irq_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  src;
  logic [4:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;
  logic        irq3;
  logic        irq4;

  int total = 0;
  int bad   = 0;

  swervolf_irq_arbiter #(.N_SRC(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_irq_src (src),
    .i_wb_adr  (adr),
    .i_wb_dat  (dat),
    .i_wb_sel  (sel),
    .i_wb_we   (we),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .o_wb_rdt  (rdt),
    .o_wb_ack  (ack),
    .o_irq3    (irq3),
    .o_irq4    (irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wb_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    adr = a; dat = d; sel = 4'h1; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_rd(input logic [4:0] a, output logic [31:0] d,
                       output logic k);
    @(negedge clk);
    adr = a; dat = '0; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    d = rdt; k = ack;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] p);
    @(negedge clk); src = p;
    @(negedge clk); src = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if (irq3 !== 1'b0 || irq4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq got=%b%b exp=00", irq3, irq4);
    end
    for (int r = 0; r < 8; r++) begin
      wb_rd(5'(r * 4), d, k);
      total++;
      if (d !== 32'h0 || k !== 1'b1) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h ack=%b exp=0 ack=1", r, d, k);
      end
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic k;
    wb_wr(5'h04, 32'h1);
    wb_wr(5'h08, 32'h0);
    wb_wr(5'h0C, 32'h0);
    @(negedge clk); src[0] = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      total++;
      if (irq3 !== (e == 3)) begin
        bad++;
        $display("FAIL level_latency edge%0d got=%b exp=%b", e, irq3, e == 3);
      end
    end
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h8000_0000 || irq3 !== 1'b0) begin
      bad++;
      $display("FAIL level_claim got=%h irq3=%b exp=80000000 irq3=0", d, irq3);
    end
    wb_wr(5'h10, 32'h0);
    @(negedge clk);
    total++;
    if (irq3 !== 1'b1) begin
      bad++;
      $display("FAIL level_reassert got=%b exp=1", irq3);
    end
    src[0] = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (irq3 !== 1'b0) begin
      bad++;
      $display("FAIL level_drop got=%b exp=0", irq3);
    end
    wb_wr(5'h04, 32'h0);
  endtask

  task automatic test_edge_priority();
    logic [31:0] d;
    logic k;
    wb_wr(5'h0C, 32'hF);
    wb_wr(5'h08, 32'h0);
    wb_wr(5'h04, 32'hF);
    pulse(4'b0110);
    total++;
    if (irq3 !== 1'b1) begin
      bad++;
      $display("FAIL edge_assert got=%b exp=1", irq3);
    end
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h8000_0001) begin
      bad++;
      $display("FAIL edge_claim1 got=%h exp=80000001", d);
    end
    wb_wr(5'h10, 32'h1);
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h8000_0002) begin
      bad++;
      $display("FAIL edge_claim2 got=%h exp=80000002", d);
    end
    wb_wr(5'h10, 32'h2);
    wb_rd(5'h00, d, k);
    total++;
    if (d !== 32'h0 || irq3 !== 1'b0) begin
      bad++;
      $display("FAIL edge_pending got=%h irq3=%b exp=0 irq3=0", d, irq3);
    end
  endtask

  task automatic test_routing();
    logic [31:0] d;
    logic k;
    wb_wr(5'h08, 32'h8);
    wb_wr(5'h04, 32'h9);
    pulse(4'b1001);
    total++;
    if (irq3 !== 1'b1 || irq4 !== 1'b1) begin
      bad++;
      $display("FAIL route_both got=%b%b exp=11", irq3, irq4);
    end
    wb_rd(5'h14, d, k);
    total++;
    if (d !== 32'h8000_0003 || irq3 !== 1'b1 || irq4 !== 1'b0) begin
      bad++;
      $display("FAIL route_claim4 got=%h irq=%b%b exp=80000003 irq=10",
               d, irq3, irq4);
    end
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h8000_0000) begin
      bad++;
      $display("FAIL route_claim3 got=%h exp=80000000", d);
    end
    wb_wr(5'h10, 32'h0);
    wb_wr(5'h14, 32'h3);
    @(negedge clk);
    total++;
    if (irq3 !== 1'b0 || irq4 !== 1'b0) begin
      bad++;
      $display("FAIL route_idle got=%b%b exp=00", irq3, irq4);
    end
  endtask

  task automatic test_mismatch();
    logic [31:0] d;
    logic k;
    wb_wr(5'h08, 32'h0);
    wb_wr(5'h04, 32'hF);
    pulse(4'b0010);
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h8000_0001) begin
      bad++;
      $display("FAIL mis_claim got=%h exp=80000001", d);
    end
    wb_wr(5'h10, 32'h2);
    @(negedge clk);
    total++;
    if (irq3 !== 1'b0) begin
      bad++;
      $display("FAIL mis_irq got=%b exp=0", irq3);
    end
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL mis_claim_again got=%h exp=0", d);
    end
    wb_wr(5'h10, 32'h1);
    pulse(4'b0001);
    total++;
    if (irq3 !== 1'b1) begin
      bad++;
      $display("FAIL mis_left_service got=%b exp=1", irq3);
    end
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h8000_0000) begin
      bad++;
      $display("FAIL mis_next_claim got=%h exp=80000000", d);
    end
    wb_wr(5'h10, 32'h0);
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    logic k;
    wb_wr(5'h04, 32'h0);
    @(negedge clk); src[0] = 1'b1;
    @(negedge clk); src[0] = 1'b0;
    adr = 5'h00; dat = 32'h1; sel = 4'h1; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_rd(5'h00, d, k);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL w1c_race got=%h exp=1", d);
    end
    wb_wr(5'h00, 32'h1);
    wb_rd(5'h00, d, k);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL w1c_clear got=%h exp=0", d);
    end
  endtask

  task automatic test_reset_midservice();
    logic [31:0] d;
    logic k;
    wb_wr(5'h08, 32'h2);
    wb_wr(5'h04, 32'h3);
    pulse(4'b0011);
    total++;
    if (irq3 !== 1'b1 || irq4 !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got=%b%b exp=11", irq3, irq4);
    end
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rst_claim got=%h exp=80000000", d);
    end
    @(negedge clk);
    rst = 1'b1;
    adr = 5'h04; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    total++;
    if (irq3 !== 1'b0 || irq4 !== 1'b0 || ack !== 1'b0 || rdt !== 32'h0) begin
      bad++;
      $display("FAIL rst_outputs got irq=%b%b ack=%b rdt=%h exp all 0",
               irq3, irq4, ack, rdt);
    end
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    wb_rd(5'h04, d, k);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL rst_enable got=%h exp=0", d);
    end
    wb_rd(5'h10, d, k);
    total++;
    if (d !== 32'h0 || irq4 !== 1'b0) begin
      bad++;
      $display("FAIL rst_claim3 got=%h irq4=%b exp=0 irq4=0", d, irq4);
    end
  endtask

  initial begin
    rst = 1'b1; src = '0; adr = '0; dat = '0; sel = '0;
    we = 1'b0; cyc = 1'b0; stb = 1'b0;
    test_reset();
    test_level();
    test_edge_priority();
    test_routing();
    test_mismatch();
    test_w1c_race();
    test_reset_midservice();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
